decoder_n_to_2n_seq: RTL and testbench
======================================

Name: decoder_n_to_2n_seq

Overview:
Registered, parametrised N-to-2^N binary-to-one-hot decoder with two operating modes.
- Direct mode: decodes a select value accepted over a valid/ready handshake.
- Scan mode: autonomously walks a single hot bit across all outputs with a programmable dwell time. Used for display-digit multiplexing and row strobing.
- Successor to the fixed 3-to-8 combinational decoder; sits between control logic and output strobes.

Parameters:
- N, 3, select width; output width is 2^N.
- DWELL_W, 8, width of dwell counter and dwell input.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- en  input  1  block enable; low forces IDLE
- mode  input  1  0 = direct decode, 1 = scan
- sel_valid  input  1  select value offered
- sel_ready  output  1  block accepts select (combinational)
- sel  input  N  binary select
- dwell  input  DWELL_W  cycles per scan position minus one
- Y  output  2^N  registered one-hot output (all-zero when inactive)
- y_valid  output  1  Y holds a decoded/scan value
- scan_idx  output  N  current scan position
- wrap  output  1  one-cycle pulse when scan wraps from 2^N-1 to 0

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous, active-low. Assert is asynchronous; deassert is sampled on clk.
- Reset values: Y=0, y_valid=0, scan_idx=0, wrap=0, dwell_cnt=0, state=IDLE. sel_ready=0, derived from state.
- Invariant: Y is always one-hot or all-zero, never multi-hot.
- States:
  - IDLE: Y=0, y_valid=0. en=1 with mode=0 -> DIRECT. en=1 with mode=1 -> SCAN.
  - Entering SCAN: scan_idx=0, dwell_cnt=0, Y=1<<0, y_valid=1 on the entry edge.
- DIRECT:
  - sel_ready = en & ~mode & (state==DIRECT).
  - On sel_valid & sel_ready at edge k: Y=1<<sel and y_valid=1 visible after edge k (one-cycle latency).
  - Y holds until the next accepted sel; back-to-back accepts every cycle are allowed.
  - On entry from IDLE or SCAN: Y=0 and y_valid=0 until the first accept.
- SCAN:
  - sel_ready=0; sel is ignored.
  - dwell_cnt increments each cycle. When dwell_cnt==dwell: dwell_cnt<=0 and scan_idx<=scan_idx+1, mod 2^N. Y follows 1<<scan_idx on the same edge.
  - dwell is compared live, not latched. dwell=0 advances every cycle.
  - If dwell is lowered below dwell_cnt, the counter wraps through 2^DWELL_W before matching. This is accepted behaviour, not an error.
  - wrap=1 for exactly the cycle after scan_idx goes 2^N-1 -> 0.
- Mode change while en=1 takes effect on the next edge:
  - DIRECT->SCAN restarts the scan at index 0.
  - SCAN->DIRECT clears Y and y_valid.
  - A mode change takes priority over a coincident sel_valid; no accept occurs, since sel_ready is already 0.
- en=0 in any state: next edge -> IDLE, Y=0, y_valid=0, wrap=0. scan_idx is held and is reset to 0 on the next SCAN entry.
- Reset mid-operation: all outputs go to their reset values immediately, without waiting for a clock edge.
- scan_idx in DIRECT/IDLE: holds its last value; consumers ignore it unless mode=1.

Optional Feature:
Macro DECODER_OUT_INVERT_EN.
- Defined: the Y port is driven as the bitwise inverse of the internal one-hot vector (one-cold, for common-anode displays). Reset and inactive value becomes all-ones. y_valid, wrap and scan_idx are unchanged.
- Undefined: Y is active-high as described above.
- The internal register and checker logic are identical in both builds; the inversion is on the output only.

Decomposition:
- Package decoder_pkg holds:
  - state encodings ST_IDLE=2'd0, ST_DIRECT=2'd1, ST_SCAN=2'd2
  - mode constants MODE_DIRECT=1'b0, MODE_SCAN=1'b1
- Sub-module onehot_dec: purely combinational N -> 2^N decoder, parametrised on N. One instance feeds the Y register, muxed between sel (DIRECT) and next scan_idx (SCAN).
- FSM, dwell counter and handshake stay in the top module.

Test Plan:
1. Reset: rst_n=0 asserted mid-scan, async between edges -> Y=8'h00, y_valid=0, wrap=0, sel_ready=0 immediately.
2. Direct decode, N=3: en=1, mode=0, sel=5 with sel_valid=1 -> one cycle later Y=8'h20, y_valid=1. Then back-to-back sel=0,7 -> Y=8'h01 then 8'h80 on consecutive cycles.
3. Scan dwell: N=3, dwell=2, mode=1:
   - Y steps 01,02,04,...,80, each held for exactly 3 cycles.
   - wrap pulses once, one cycle, as Y returns to 8'h01.
   - Repeat with dwell=0 -> Y shifts every cycle.
4. Mode priority: in DIRECT with Y=8'h08, set mode=1 and sel_valid=1 in the same cycle -> no accept, next Y=8'h01, scan_idx=0.
5. Enable drop: en=0 during SCAN at scan_idx=4 -> next edge Y=0, y_valid=0. Re-enable -> scan restarts with Y=8'h01.
6. DECODER_OUT_INVERT_EN build: repeat test 2 -> after reset Y=8'hFF, after sel=5 Y=8'hDF.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared constants for the registered N-to-2^N decoder: FSM encodings and mode values.
package decoder_pkg;
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DIRECT = 2'd1;
    localparam logic [1:0] ST_SCAN   = 2'd2;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;
endpackage

// File: rtl/onehot_dec.sv
// Purely combinational N -> 2^N binary-to-one-hot decoder.
module onehot_dec #(
    parameter int N = 3
) (
    input  logic [N-1:0]    idx,
    output logic [2**N-1:0] onehot
);
    always_comb begin
        onehot      = '0;
        onehot[idx] = 1'b1;
    end
endmodule

// File: rtl/decoder_n_to_2n_seq.sv
// Registered N-to-2^N one-hot decoder with direct (handshaked) and scan (dwell-timed walk) modes.
// Define DECODER_OUT_INVERT_EN to drive Y one-cold (inverted) for common-anode loads.
module decoder_n_to_2n_seq
    import decoder_pkg::*;
#(
    parameter int N       = 3,
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               mode,
    input  logic               sel_valid,
    output logic               sel_ready,
    input  logic [N-1:0]       sel,
    input  logic [DWELL_W-1:0] dwell,
    output logic [2**N-1:0]    Y,
    output logic               y_valid,
    output logic [N-1:0]       scan_idx,
    output logic               wrap
);
    localparam int W = 2**N;

    logic [1:0]         state_q, state_d;
    logic [W-1:0]       y_q, y_d;
    logic               y_valid_q, y_valid_d;
    logic [N-1:0]       scan_idx_q, scan_idx_d;
    logic               wrap_q, wrap_d;
    logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
    logic               y_load, y_clr;
    logic [N-1:0]       dec_idx;
    logic [W-1:0]       dec_onehot;

    assign sel_ready = en & (mode == MODE_DIRECT) & (state_q == ST_DIRECT);

    always_comb begin
        state_d     = state_q;
        y_valid_d   = y_valid_q;
        scan_idx_d  = scan_idx_q;
        dwell_cnt_d = dwell_cnt_q;
        wrap_d      = 1'b0;
        y_load      = 1'b0;
        y_clr       = 1'b0;
        dec_idx     = sel;
        if (!en) begin
            state_d   = ST_IDLE;
            y_valid_d = 1'b0;
            y_clr     = 1'b1;
        end else if (mode == MODE_SCAN) begin
            state_d   = ST_SCAN;
            y_valid_d = 1'b1;
            y_load    = 1'b1;
            if (state_q != ST_SCAN) begin
                scan_idx_d  = '0;
                dwell_cnt_d = '0;
            end else if (dwell_cnt_q == dwell) begin
                // dwell is compared live; lowering it below the count wraps the counter
                dwell_cnt_d = '0;
                scan_idx_d  = scan_idx_q + 1'b1;
                wrap_d      = &scan_idx_q;
            end else begin
                dwell_cnt_d = dwell_cnt_q + 1'b1;
            end
            dec_idx = scan_idx_d;
        end else begin
            state_d = ST_DIRECT;
            if (state_q != ST_DIRECT) begin
                y_valid_d = 1'b0;
                y_clr     = 1'b1;
            end else if (sel_valid) begin
                y_valid_d = 1'b1;
                y_load    = 1'b1;
            end
        end
    end

    onehot_dec #(.N(N)) u_dec (
        .idx    (dec_idx),
        .onehot (dec_onehot)
    );

    // Kept apart from the FSM block so the decoder sits outside any comb loop.
    always_comb begin
        y_d = y_q;
        if (y_clr)
            y_d = '0;
        else if (y_load)
            y_d = dec_onehot;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            y_q         <= '0;
            y_valid_q   <= 1'b0;
            scan_idx_q  <= '0;
            wrap_q      <= 1'b0;
            dwell_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            y_q         <= y_d;
            y_valid_q   <= y_valid_d;
            scan_idx_q  <= scan_idx_d;
            wrap_q      <= wrap_d;
            dwell_cnt_q <= dwell_cnt_d;
        end
    end

`ifdef DECODER_OUT_INVERT_EN
    assign Y = ~y_q;
`else
    assign Y = y_q;
`endif
    assign y_valid  = y_valid_q;
    assign scan_idx = scan_idx_q;
    assign wrap     = wrap_q;
endmodule

// File: tb/tb_decoder_n_to_2n_seq.sv
// Directed bench for decoder_n_to_2n_seq: behavioural model checked every cycle plus literal pins.
module tb_decoder_n_to_2n_seq;
    localparam int N       = 3;
    localparam int DWELL_W = 8;
    localparam int W       = 2**N;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               en, mode, sel_valid, sel_ready;
    logic [N-1:0]       sel;
    logic [DWELL_W-1:0] dwell;
    logic [W-1:0]       Y;
    logic               y_valid, wrap;
    logic [N-1:0]       scan_idx;

    int n_chk  = 0;
    int n_fail = 0;
    int wraps;

    decoder_n_to_2n_seq #(.N(N), .DWELL_W(DWELL_W)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
        .sel_valid(sel_valid), .sel_ready(sel_ready), .sel(sel), .dwell(dwell),
        .Y(Y), .y_valid(y_valid), .scan_idx(scan_idx), .wrap(wrap)
    );

    always #5 clk = ~clk;

    // Map an active-high one-hot vector to what the Y pin must show in this build.
    function automatic logic [W-1:0] pin(input logic [W-1:0] v);
`ifdef DECODER_OUT_INVERT_EN
        return ~v;
`else
        return v;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: activity (0 idle, 1 direct, 2 scan), lit position, time spent on it.
    int m_act, m_hot, m_pos, m_age;
    bit m_valid, m_wrap;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_act <= 0; m_hot <= -1; m_pos <= 0; m_age <= 0; m_valid <= 0; m_wrap <= 0;
        end else if (!en) begin
            m_act <= 0; m_hot <= -1; m_valid <= 0; m_wrap <= 0;
        end else if (mode) begin
            m_act <= 2; m_valid <= 1;
            if (m_act != 2) begin
                m_pos <= 0; m_hot <= 0; m_age <= 0; m_wrap <= 0;
            end else if (m_age == int'(dwell)) begin
                m_age  <= 0;
                m_pos  <= (m_pos + 1) % W;
                m_hot  <= (m_pos + 1) % W;
                m_wrap <= (m_pos == W - 1);
            end else begin
                m_age  <= (m_age + 1) % (2**DWELL_W);
                m_wrap <= 0;
            end
        end else begin
            m_act <= 1; m_wrap <= 0;
            if (m_act != 1) begin
                m_hot <= -1; m_valid <= 0;
            end else if (sel_valid) begin
                m_hot <= int'(sel); m_valid <= 1;
            end
        end
    end

    always @(negedge clk) begin
        logic [W-1:0] ev;
        ev = (m_hot < 0) ? '0 : (W'(1) << m_hot);
        chk("model_Y", Y, pin(ev));
        chk("model_y_valid", y_valid, m_valid);
        chk("model_wrap", wrap, m_wrap);
        chk("model_scan_idx", scan_idx, m_pos[N-1:0]);
        chk("model_sel_ready", sel_ready, en && !mode && m_act == 1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; mode = 1'b0; sel_valid = 1'b0; sel = '0; dwell = '0;
        tick(); tick();
        chk("reset_Y", Y, pin(8'h00));
        chk("reset_y_valid", y_valid, 1'b0);
        rst_n = 1'b1;
        tick();

        // Direct decode with back-to-back accepts
        en = 1'b1; mode = 1'b0;
        tick();
        chk("direct_entry_Y", Y, pin(8'h00));
        sel = 3'd5; sel_valid = 1'b1;
        tick();
        chk("direct_sel5", Y, pin(8'h20));
        chk("direct_valid", y_valid, 1'b1);
        sel = 3'd0;
        tick();
        chk("direct_sel0", Y, pin(8'h01));
        sel = 3'd7;
        tick();
        chk("direct_sel7", Y, pin(8'h80));
        sel_valid = 1'b0; sel = 3'd2;
        tick();
        chk("direct_hold", Y, pin(8'h80));
        for (int i = 0; i < 12; i++) begin
            sel = N'($urandom_range(0, W - 1));
            sel_valid = 1'($urandom_range(0, 1));
            tick();
        end

        // Mode change beats a coincident sel_valid
        sel = 3'd3; sel_valid = 1'b1;
        tick();
        chk("prio_pre_Y", Y, pin(8'h08));
        dwell = 8'd2; mode = 1'b1; sel = 3'd6;
        #1;
        chk("prio_ready_low", sel_ready, 1'b0);
        tick();
        sel_valid = 1'b0;
        chk("prio_Y", Y, pin(8'h01));
        chk("prio_idx", scan_idx, 3'd0);

        // Scan with dwell=2: each position held 3 cycles, single wrap pulse
        wraps = 0;
        for (int p = 0; p < W; p++) begin
            for (int c = 0; c < 3; c++) begin
                chk("scan_d2_Y", Y, pin(W'(1) << p));
                if (wrap) wraps++;
                tick();
            end
        end
        chk("scan_d2_nowrap_inside", wraps, 0);
        chk("scan_d2_back_to_01", Y, pin(8'h01));
        chk("scan_d2_wrap", wrap, 1'b1);

        // dwell=0: shift every cycle
        dwell = 8'd0;
        tick();
        chk("scan_d0_wrap_one_cycle", wrap, 1'b0);
        chk("scan_d0_Y1", Y, pin(8'h02));
        for (int p = 2; p < W; p++) begin
            tick();
            chk("scan_d0_Y", Y, pin(W'(1) << p));
        end
        tick();
        chk("scan_d0_wrapY", Y, pin(8'h01));
        chk("scan_d0_wrap", wrap, 1'b1);
        tick(); tick(); tick(); tick();

        // Enable drop at index 4, then restart
        chk("endrop_idx4", scan_idx, 3'd4);
        chk("endrop_Y10", Y, pin(8'h10));
        en = 1'b0;
        tick();
        chk("endrop_Y", Y, pin(8'h00));
        chk("endrop_valid", y_valid, 1'b0);
        chk("endrop_idx_held", scan_idx, 3'd4);
        en = 1'b1;
        tick();
        chk("reenable_Y", Y, pin(8'h01));
        chk("reenable_idx", scan_idx, 3'd0);

        // Lower dwell below the running count: counter wraps through 2^DWELL_W
        dwell = 8'd5;
        tick(); tick(); tick(); tick();
        dwell = 8'd1;
        repeat (260) tick();

        // Scan -> direct clears the output
        mode = 1'b0;
        tick();
        chk("s2d_Y", Y, pin(8'h00));
        chk("s2d_valid", y_valid, 1'b0);

        // Async reset mid-scan, between edges
        mode = 1'b1; dwell = 8'd2;
        repeat (5) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_Y", Y, pin(8'h00));
        chk("async_rst_valid", y_valid, 1'b0);
        chk("async_rst_wrap", wrap, 1'b0);
        chk("async_rst_ready", sel_ready, 1'b0);
        tick();
        rst_n = 1'b1; en = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
